// File: rtl/cluster_periph_req_router_pkg.sv
// Shared types, address map and target decode for the cluster peripheral request router.
package cluster_periph_req_router_pkg;

    localparam logic [31:0] BaseAddr = 32'h1020_0000;
    localparam int          NbSlv    = 11;
    localparam int          SlotLog2 = 10;
    localparam int          WinLog2  = SlotLog2 + 4;
    localparam int          MaxOutst = 4;
    localparam logic [31:0] ErrRdata = 32'hBADA_CCE5;

    localparam int SPER_EOC_ID      = 0;
    localparam int SPER_TIMER_ID    = 1;
    localparam int SPER_EVENT_U_ID  = 2;
    localparam int SPER_EVENT_U2_ID = 3;
    localparam int SPER_HWPE_ID     = 4;
    localparam int SPER_ICACHE_ID   = 5;
    localparam int SPER_DMA_CL_ID   = 6;
    localparam int SPER_DMA_FC_ID   = 7;
    localparam int SPER_HMR_ID      = 8;
    localparam int SPER_SCRUBBER_ID = 9;
    localparam int SPER_HCI_ECC_ID  = 10;
    localparam int SPER_EXT_ID      = 11;

    typedef logic [$clog2(NbSlv+1)-1:0] periph_tgt_t;
    localparam periph_tgt_t PERIPH_TGT_ERR = periph_tgt_t'(SPER_EXT_ID);

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        logic [31:0] data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic        gnt;
        logic        r_valid;
        logic [31:0] r_data;
    } core_data_rsp_t;

    // Slots at or above NbSlv, and anything outside the 16 KiB window, go to the error slave.
    function automatic periph_tgt_t decode_tgt(input logic [31:0] add);
        logic [WinLog2-SlotLog2-1:0] slot;
        slot = add[WinLog2-1:SlotLog2];
        if (add[31:WinLog2] == BaseAddr[31:WinLog2] && int'(slot) < NbSlv) begin
            return periph_tgt_t'(slot);
        end
        return PERIPH_TGT_ERR;
    endfunction

endpackage

// File: rtl/cluster_periph_req_router_if.sv
// Core-side and peripheral-side request/response bundle of the router.
interface cluster_periph_req_router_if;
    import cluster_periph_req_router_pkg::*;

    core_data_req_t             core_req;
    core_data_rsp_t             core_rsp;
    core_data_req_t [NbSlv-1:0] per_req;
    core_data_rsp_t [NbSlv-1:0] per_rsp;

    modport slave  (input core_req, output core_rsp, output per_req, input per_rsp);
    modport master (output core_req, input core_rsp, input per_req, output per_rsp);
endinterface

// File: rtl/cluster_periph_req_router_err_slv.sv
// Error responder for unmapped accesses: answers one cycle after the grant; writes are dropped.
module cluster_periph_req_router_err_slv
    import cluster_periph_req_router_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        r_valid_o,
    output logic [31:0] r_data_o
);

    logic r_valid_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_valid_q <= 1'b0;
        else         r_valid_q <= req_i;
    end

    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_valid_q ? ErrRdata : '0;

endmodule

// File: rtl/cluster_periph_req_router.sv
// Address-decoding request router with in-order response return via a route FIFO.
// Optional sticky unmapped-access log: define CLUSTER_PERIPH_ROUTER_ERR_LOG_EN.
module cluster_periph_req_router
    import cluster_periph_req_router_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_ni,
    cluster_periph_req_router_if.slave        bus,
    output logic                              busy_o,
    output logic                              err_valid_o,
    output logic [31:0]                       err_addr_o,
    input  logic                              err_clear_i
);

    localparam int PtrW = $clog2(MaxOutst);
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    periph_tgt_t fifo_q [MaxOutst];
    ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t        cnt_q, cnt_d;
    periph_tgt_t last_tgt_q, tgt, head;

    logic        empty, full, allow, slv_gnt, push, pop;
    logic        rsp_valid, err_req, err_rvalid;
    logic [31:0] rsp_data, err_rdata;
    core_data_req_t [NbSlv-1:0] per_req;

    assign tgt   = decode_tgt(bus.core_req.add);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == cnt_t'(MaxOutst));
    assign head  = fifo_q[rd_ptr_q];

    // Only one slave may be outstanding at a time, so responses cannot overtake each other.
    assign pop     = !empty && rsp_valid;
    assign allow   = !(full && !pop) && (empty || tgt == last_tgt_q);
    assign push    = bus.core_req.req && allow && slv_gnt;
    assign err_req = push && (tgt == PERIPH_TGT_ERR);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        slv_gnt   = 1'b1;
        rsp_valid = err_rvalid;
        rsp_data  = err_rdata;
        for (int i = 0; i < NbSlv; i++) begin
            per_req[i]     = bus.core_req;
            per_req[i].req = bus.core_req.req && allow && (tgt == periph_tgt_t'(i));
            if (tgt == periph_tgt_t'(i)) slv_gnt = bus.per_rsp[i].gnt;
            if (head == periph_tgt_t'(i)) begin
                rsp_valid = bus.per_rsp[i].r_valid;
                rsp_data  = bus.per_rsp[i].r_data;
            end
        end
    end

    assign bus.per_req          = per_req;
    assign bus.core_rsp.gnt     = push;
    assign bus.core_rsp.r_valid = pop;
    assign bus.core_rsp.r_data  = pop ? rsp_data : '0;
    assign busy_o               = !empty;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + cnt_t'(1);
        else if (pop && !push) cnt_d = cnt_q - cnt_t'(1);
    end

    // NOTE: the route storage is reset so the head is defined straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutst; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_tgt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= tgt;
                last_tgt_q       <= tgt;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    cluster_periph_req_router_err_slv i_err_slv (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (err_req),
        .r_valid_o (err_rvalid),
        .r_data_o  (err_rdata)
    );

`ifdef CLUSTER_PERIPH_ROUTER_ERR_LOG_EN
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Clear has priority over a capture in the same cycle.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end else if (err_req && !err_valid_q) begin
            err_valid_d = 1'b1;
            err_addr_d  = bus.core_req.add;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear_i;
    assign err_valid_o      = 1'b0;
    assign err_addr_o       = '0;
`endif

    for (genvar g = 0; g < NbSlv; g++) begin : g_rsp_chk
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.per_rsp[g].r_valid |-> (!empty && head == periph_tgt_t'(g)))
            else $error("router: r_valid from slave %0d with no matching outstanding request", g);
    end

endmodule

// File: tb/tb_cluster_periph_req_router.sv
// Directed testbench for cluster_periph_req_router; expected values are hand-computed.
module tb_cluster_periph_req_router;
    import cluster_periph_req_router_pkg::*;

`ifdef CLUSTER_PERIPH_ROUTER_ERR_LOG_EN
    localparam bit LogEn = 1'b1;
`else
    localparam bit LogEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        err_clear_i = 1'b0;
    logic        busy_o, err_valid_o;
    logic [31:0] err_addr_o;
    int          n_vec = 0;
    int          n_err = 0;

    cluster_periph_req_router_if bus ();

    cluster_periph_req_router dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .busy_o      (busy_o),
        .err_valid_o (err_valid_o),
        .err_addr_o  (err_addr_o),
        .err_clear_i (err_clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        bus.core_req = '{req: 1'b1, add: a, we: 1'b0, data: 32'h0, be: 4'hF};
    endtask

    task automatic clr_rsp();
        for (int i = 0; i < NbSlv; i++) bus.per_rsp[i] = '0;
    endtask

    function automatic logic any_per_req();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NbSlv; i++) r |= bus.per_req[i].req;
        return r;
    endfunction

    initial begin
        bus.core_req = '0;
        clr_rsp();
        #12;
        check("rst gnt",       bus.core_rsp.gnt, 1'b0);
        check("rst rvalid",    bus.core_rsp.r_valid, 1'b0);
        check("rst rdata",     bus.core_rsp.r_data, 32'h0);
        check("rst per_req",   any_per_req(), 1'b0);
        check("rst busy",      busy_o, 1'b0);
        check("rst err_valid", err_valid_o, 1'b0);
        check("rst err_addr",  err_addr_o, 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: single timer read
        rd(32'h1020_0400);
        bus.per_rsp[1].gnt = 1'b1;
        settle();
        check("t1 per_req1", bus.per_req[1].req, 1'b1);
        check("t1 per_req0", bus.per_req[0].req, 1'b0);
        check("t1 gnt",      bus.core_rsp.gnt, 1'b1);
        tick();
        bus.core_req.req = 1'b0;
        bus.per_rsp[1] = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h1234};
        settle();
        check("t1 busy",   busy_o, 1'b1);
        check("t1 rvalid", bus.core_rsp.r_valid, 1'b1);
        check("t1 rdata",  bus.core_rsp.r_data, 32'h1234);
        tick();
        clr_rsp();
        settle();
        check("t1 busy0",   busy_o, 1'b0);
        check("t1 rvalid0", bus.core_rsp.r_valid, 1'b0);

        // 2: four back-to-back event-unit reads fill the FIFO
        rd(32'h1020_0800);
        bus.per_rsp[2].gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("t2 gnt", bus.core_rsp.gnt, 1'b1);
            tick();
        end
        settle();
        check("t2 full gnt", bus.core_rsp.gnt, 1'b0);
        check("t2 full per_req", bus.per_req[2].req, 1'b0);
        tick();
        settle();
        check("t2 full gnt2", bus.core_rsp.gnt, 1'b0);
        tick();
        bus.per_rsp[2].r_valid = 1'b1;
        bus.per_rsp[2].r_data  = 32'hE0;
        settle();
        check("t2 pop rdata",  bus.core_rsp.r_data, 32'hE0);
        check("t2 push+pop gnt", bus.core_rsp.gnt, 1'b1);
        tick();
        bus.core_req.req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.per_rsp[2].r_data = 32'hE0 + 32'(k);
            settle();
            check("t2 busy",  busy_o, 1'b1);
            check("t2 rdata", bus.core_rsp.r_data, 32'hE0 + 32'(k));
            tick();
        end
        clr_rsp();
        settle();
        check("t2 busy0", busy_o, 1'b0);

        // 3: DMA read blocked behind two timer reads
        rd(32'h1020_0400);
        bus.per_rsp[1].gnt = 1'b1;
        tick();
        tick();
        rd(32'h1020_1800);
        bus.per_rsp[1].gnt = 1'b0;
        bus.per_rsp[6].gnt = 1'b1;
        settle();
        check("t3 blocked gnt",  bus.core_rsp.gnt, 1'b0);
        check("t3 blocked req6", bus.per_req[6].req, 1'b0);
        check("t3 bcast add",    bus.per_req[6].add, 32'h1020_1800);
        tick();
        bus.per_rsp[1].r_valid = 1'b1;
        bus.per_rsp[1].r_data  = 32'h11;
        settle();
        check("t3 rdata1",   bus.core_rsp.r_data, 32'h11);
        check("t3 gnt cnt2", bus.core_rsp.gnt, 1'b0);
        tick();
        bus.per_rsp[1].r_data = 32'h22;
        settle();
        check("t3 rdata2",   bus.core_rsp.r_data, 32'h22);
        check("t3 gnt cnt1", bus.core_rsp.gnt, 1'b0);
        tick();
        bus.per_rsp[1].r_valid = 1'b0;
        settle();
        check("t3 gnt empty", bus.core_rsp.gnt, 1'b1);
        check("t3 req6",      bus.per_req[6].req, 1'b1);
        tick();
        bus.core_req.req = 1'b0;
        bus.per_rsp[6] = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h66};
        settle();
        check("t3 rdata6", bus.core_rsp.r_data, 32'h66);
        tick();
        clr_rsp();
        settle();
        check("t3 busy0", busy_o, 1'b0);

        // 4: unmapped slot 11 then outside the window, back to back
        rd(32'h1020_2C00);
        settle();
        check("t4 gnt",     bus.core_rsp.gnt, 1'b1);
        check("t4 per_req", any_per_req(), 1'b0);
        tick();
        rd(32'h2000_0000);
        settle();
        check("t4 gnt2",      bus.core_rsp.gnt, 1'b1);
        check("t4 per_req2",  any_per_req(), 1'b0);
        check("t4 rvalid",    bus.core_rsp.r_valid, 1'b1);
        check("t4 rdata",     bus.core_rsp.r_data, 32'hBADA_CCE5);
        check("t4 err_valid", err_valid_o, LogEn);
        check("t4 err_addr",  err_addr_o, LogEn ? 32'h1020_2C00 : 32'h0);
        tick();
        bus.core_req.req = 1'b0;
        settle();
        check("t4 rdata2",    bus.core_rsp.r_data, 32'hBADA_CCE5);
        check("t4 err_first", err_addr_o, LogEn ? 32'h1020_2C00 : 32'h0);
        tick();
        settle();
        check("t4 rvalid0", bus.core_rsp.r_valid, 1'b0);
        check("t4 busy0",   busy_o, 1'b0);

        // 5: clear in the same cycle as a new unmapped grant
        rd(32'h1020_3C00);
        err_clear_i = 1'b1;
        settle();
        check("t5 gnt", bus.core_rsp.gnt, 1'b1);
        tick();
        bus.core_req.req = 1'b0;
        err_clear_i = 1'b0;
        settle();
        check("t5 err_valid", err_valid_o, 1'b0);
        check("t5 err_addr",  err_addr_o, 32'h0);
        check("t5 rvalid",    bus.core_rsp.r_valid, 1'b1);
        tick();
        settle();
        check("t5 busy0", busy_o, 1'b0);

        // 6: asynchronous reset with three timer reads outstanding
        rd(32'h1020_0400);
        bus.per_rsp[1].gnt = 1'b1;
        tick();
        tick();
        tick();
        bus.core_req.req = 1'b0;
        bus.per_rsp[1].gnt = 1'b0;
        settle();
        check("t6 busy", busy_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        bus.core_req = '0;
        #1;
        check("t6 rst busy",    busy_o, 1'b0);
        check("t6 rst gnt",     bus.core_rsp.gnt, 1'b0);
        check("t6 rst rvalid",  bus.core_rsp.r_valid, 1'b0);
        check("t6 rst per_req", any_per_req(), 1'b0);
        bus.per_rsp[1].r_valid = 1'b1;
        bus.per_rsp[1].r_data  = 32'h99;
        tick();
        settle();
        check("t6 late rvalid", bus.core_rsp.r_valid, 1'b0);
        check("t6 late rdata",  bus.core_rsp.r_data, 32'h0);
        clr_rsp();
        tick();
        rst_ni = 1'b1;
        tick();
        rd(32'h1020_0400);
        bus.per_rsp[1].gnt = 1'b1;
        settle();
        check("t6 post gnt", bus.core_rsp.gnt, 1'b1);
        tick();
        bus.core_req.req = 1'b0;
        bus.per_rsp[1] = '{gnt: 1'b0, r_valid: 1'b1, r_data: 32'h55};
        settle();
        check("t6 post rdata", bus.core_rsp.r_data, 32'h55);
        tick();
        clr_rsp();
        settle();
        check("t6 post busy0", busy_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
